// File: rtl/sipo_deserializer.sv
// sipo_deserializer: assembles WIDTH-bit words from a framed serial bit stream.
// A one-word holding register presents each word on a valid/ready port. A word
// that completes while the holding register is still occupied is dropped, and
// the sticky overrun bit records the drop.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         start,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         overrun,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sr_next;
  logic             accept;
  logic             word_first;
  logic             done;
  logic             load;

  // Next shift-register value and word-completion decode.
  always_comb begin
    accept     = din_valid && ((state == SHIFT) || start);
    // A new word starts on start, or on the first bit after a completed word.
    // Clearing the base keeps stale bits out of the new word.
    word_first = start || (bit_cnt == '0);
    base       = word_first ? '0 : sr;
    if (MSB_FIRST) sr_next = {base[WIDTH-2:0], din};
    else           sr_next = {din, base[WIDTH-1:1]};
    // A start bit is always bit 0, and WIDTH >= 2, so it can never complete a word.
    done       = accept && !start && (bit_cnt == LAST);
    load       = done && (!dout_valid || dout_ready);
  end

  // Framing FSM, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sr      <= '0;
    end else if (accept) begin
      state <= SHIFT;
      sr    <= sr_next;
      if (done)       bit_cnt <= '0;
      else if (start) bit_cnt <= CW'(1);
      else            bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Holding register with valid/ready handshake. A load on the same edge as a
  // consume wins, so dout_valid stays high.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= sr_next;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!clrn)              overrun <= 1'b0;
    else if (done && !load) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer. Two instances share one stimulus stream:
// dm is MSB-first and dl is LSB-first. Each word sent pushes its expected
// value for both instances into a queue. A negedge monitor pops and compares
// whenever a transfer (valid && ready) is about to happen.
module tb_sipo_deserializer;

  logic       clk;
  logic       clrn;
  logic       din;
  logic       din_valid;
  logic       start;
  logic       dout_ready;
  logic [7:0] m_dout, l_dout;
  logic       m_valid, l_valid;
  logic       m_ovr, l_ovr;
  logic [3:0] m_cnt, l_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dm (
    .clk(clk), .clrn(clrn), .din(din), .din_valid(din_valid), .start(start),
    .dout(m_dout), .dout_valid(m_valid), .dout_ready(dout_ready),
    .overrun(m_ovr), .bit_cnt(m_cnt));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dl (
    .clk(clk), .clrn(clrn), .din(din), .din_valid(din_valid), .start(start),
    .dout(l_dout), .dout_valid(l_valid), .dout_ready(dout_ready),
    .overrun(l_ovr), .bit_cnt(l_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // Present one input set, let the next posedge sample it, and return 1 time unit after that edge.
  task automatic tick(input logic b, input logic v, input logic s);
    din = b; din_valid = v; start = s;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    clrn = 1'b1;
  endtask

  // seq[7] goes out first. The MSB-first word equals seq; the LSB-first word is seq reversed.
  task automatic send_word(input logic [7:0] seq, input bit with_start, input bit gap, input bit drop);
    for (int i = 0; i < 8; i++) begin
      tick(seq[7-i], 1'b1, 1'(with_start && i == 0));
      if (gap && i < 7) begin
        tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        check("gap_cnt", 32'(m_cnt), i + 1);
      end
    end
    if (!drop) begin
      q_m.push_back(seq);
      q_l.push_back(rev8(seq));
    end
  endtask

  // Scoreboard monitor: inputs change 1 time unit after posedge, so at negedge
  // they hold the values the next posedge will sample.
  always @(negedge clk) begin
    if (m_valid === 1'b1 && dout_ready === 1'b1) begin
      if (q_m.size() == 0) check("m_unexpected_word", 32'(m_dout), 32'hFFFF_FFFF);
      else                 check("m_word", 32'(m_dout), 32'(q_m.pop_front()));
    end
    if (l_valid === 1'b1 && dout_ready === 1'b1) begin
      if (q_l.size() == 0) check("l_unexpected_word", 32'(l_dout), 32'hFFFF_FFFF);
      else                 check("l_word", 32'(l_dout), 32'(q_l.pop_front()));
    end
  end

  initial begin
    clrn = 1'b1; din = 1'b0; din_valid = 1'b0; start = 1'b0;
    dout_ready = 1'($urandom_range(0, 1));

    // Reset with random inputs, then bits without start must be ignored.
    do_reset();
    check("rst_dout", 32'(m_dout), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_ovr", 32'(m_ovr), 0);
    check("rst_cnt", 32'(m_cnt), 0);
    for (int i = 0; i < 5; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("idle_cnt", 32'(m_cnt), 0);
    check("idle_valid", 32'(m_valid), 0);

    // Basic word with a latency check: valid for exactly one cycle.
    dout_ready = 1'b1;
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    check("lat_valid", 32'(m_valid), 1);
    check("lat_dout", 32'(m_dout), 32'hA5);
    check("lat_cnt", 32'(m_cnt), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("lat_valid_clr", 32'(m_valid), 0);

    // Continuous stream: the second word needs no start.
    send_word(8'h5A, 1'b1, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("stream_ovr", 32'(m_ovr), 0);

    // Gapped input; the LSB-first instance sees A5 as a palindrome and C0 as 03.
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    check("gap_l_dout", 32'(l_dout), 32'hA5);
    send_word(8'hC0, 1'b1, 1'b1, 1'b0);
    check("gap_l_c0", 32'(l_dout), 32'h03);
    tick(1'b0, 1'b0, 1'b0);

    // Backpressure: the second word is dropped and overrun goes sticky.
    dout_ready = 1'b0;
    send_word(8'h3C, 1'b1, 1'b0, 1'b0);
    check("bp_ovr0", 32'(m_ovr), 0);
    send_word(8'hF0, 1'b0, 1'b0, 1'b1);
    check("bp_ovr1", 32'(m_ovr), 1);
    check("bp_hold", 32'(m_dout), 32'h3C);
    check("bp_l_ovr", 32'(l_ovr), 1);
    dout_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("bp_valid_clr", 32'(m_valid), 0);
    check("bp_ovr_sticky", 32'(m_ovr), 1);

    // Resync: a partial word is discarded by a new start.
    do_reset();
    check("rs_ovr_clr", 32'(m_ovr), 0);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("rs_partial", 32'(m_cnt), 5);
    send_word(8'h81, 1'b1, 1'b0, 1'b0);
    check("rs_dout", 32'(m_dout), 32'h81);
    check("rs_ovr", 32'(m_ovr), 0);
    tick(1'b0, 1'b0, 1'b0);

    // Reset mid-word: no residue from bits sent before the reset.
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    do_reset();
    check("rmw_cnt", 32'(m_cnt), 0);
    send_word(8'h0F, 1'b1, 1'b0, 1'b0);
    check("rmw_dout", 32'(m_dout), 32'h0F);
    check("rmw_l_dout", 32'(l_dout), 32'hF0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    check("q_m_drained", 32'(q_m.size()), 0);
    check("q_l_drained", 32'(q_l.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
